// File: rtl/para_def.sv
// Shared widths, message type codes and state encoding for the stage5
// message path.
package para_def;

  localparam int MAX_MESSAGE_BITS = 256;
  localparam int message_mux_control_width = 4;

  localparam logic [3:0] message_mux_null = 4'h0;
  localparam logic [3:0] message_mux_cfg  = 4'h1;
  localparam logic [3:0] message_mux_stat = 4'h2;
  localparam logic [3:0] message_mux_k    = 4'h5;
  localparam logic [3:0] message_mux_ack  = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  function automatic logic len_legal(
    input int len,
    input int max_bytes
  );
    return (len >= 1) && (len <= max_bytes);
  endfunction

endpackage

// File: rtl/stage5_msg_serializer_if.sv
// Message-in / byte-out handshake bundle for the stage5 serializer.
// master drives messages and consumes bytes; slave is the serializer.
interface stage5_msg_serializer_if
  import para_def::*;
#(
  parameter int MSG_BYTES = MAX_MESSAGE_BITS / 8,
  parameter int CTRL_W    = message_mux_control_width,
  parameter int LEN_W     = 6
);

  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_mux_control;
  logic [8*MSG_BYTES-1:0] in_message;
  logic [LEN_W-1:0]       in_len;

  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_first;
  logic                   out_last;

  modport master (
    output in_valid,
    output in_mux_control,
    output in_message,
    output in_len,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_mux_control,
    input  in_message,
    input  in_len,
    output in_ready,
    output out_valid,
    output out_data,
    output out_first,
    output out_last,
    input  out_ready
  );

endinterface

// File: rtl/stage5_byte_select.sv
// Picks body byte idx from a packed message word, byte 0 at the MSBs.
// Indices past the word return zero.
module stage5_byte_select #(
  parameter int MSG_BYTES = 32,
  parameter int IDX_W     = 6
) (
  input  logic [8*MSG_BYTES-1:0] word_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [7:0]             data_o
);

  always_comb begin
    data_o = 8'h00;
    for (int i = 0; i < MSG_BYTES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        data_o = word_i[8*MSG_BYTES-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/stage5_msg_serializer.sv
// Serializes one packed message into a header byte (type code)
// followed by the body, MSB byte first.
module stage5_msg_serializer
  import para_def::*;
#(
  parameter int MSG_BYTES = MAX_MESSAGE_BITS / 8,
  parameter int CTRL_W    = message_mux_control_width,
  parameter int LEN_W     = 6,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 message_en,
  stage5_msg_serializer_if.slave bus,
  output logic                 busy,
  output logic                 err_len,
  output logic [CNT_W-1:0]     msg_count
);

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [8*MSG_BYTES-1:0] msg_q, msg_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [CNT_W-1:0]       msg_count_q, msg_count_d;
  logic                   err_len_q, err_len_d;

  logic       in_ready;
  logic       in_fire;
  logic       is_last;
  logic [7:0] sel_byte;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;

  stage5_byte_select #(
    .MSG_BYTES (MSG_BYTES),
    .IDX_W     (LEN_W)
  ) u_sel (
    .word_i (msg_q),
    .idx_i  (idx_q),
    .data_o (sel_byte)
  );

  assign in_ready = (state_q == ST_IDLE) && message_en;
  assign in_fire  = bus.in_valid && in_ready;
  assign is_last  = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    msg_d       = msg_q;
    ctrl_d      = ctrl_q;
    msg_count_d = msg_count_q;
    err_len_d   = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_first   = 1'b0;
    out_last    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          msg_d  = bus.in_message;
          ctrl_d = bus.in_mux_control;
          len_d  = bus.in_len;
          idx_d  = '0;
          // Illegal lengths are dropped here so BODY never sees them
          if (len_legal(int'(bus.in_len), MSG_BYTES)) begin
            state_d = ST_HDR;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_first = 1'b1;
        out_data  = 8'(ctrl_q);
        if (bus.out_ready) begin
          state_d = ST_BODY;
          idx_d   = '0;
        end
      end
      ST_BODY: begin
        out_valid = 1'b1;
        out_data  = sel_byte;
        out_last  = is_last;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d     = ST_IDLE;
            msg_count_d = msg_count_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      msg_q       <= '0;
      ctrl_q      <= '0;
      msg_count_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      msg_q       <= msg_d;
      ctrl_q      <= ctrl_d;
      msg_count_q <= msg_count_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_first = out_first;
  assign bus.out_last  = out_last;
  assign busy          = out_valid;
  assign err_len       = err_len_q;
  assign msg_count     = msg_count_q;

endmodule

// File: tb/tb_stage5_msg_serializer.sv
// Scoreboard bench for stage5_msg_serializer: expected byte frames are
// queued at accept time and popped by a monitor on each output handshake.
module tb_stage5_msg_serializer;
  import para_def::*;

  localparam int MB = 32;
  localparam int CW = 4;
  localparam int LW = 6;
  localparam int NW = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          message_en = 1'b1;
  logic          busy;
  logic          err_len;
  logic [NW-1:0] msg_count;

  stage5_msg_serializer_if #(
    .MSG_BYTES (MB),
    .CTRL_W    (CW),
    .LEN_W     (LW)
  ) bus ();

  stage5_msg_serializer #(
    .MSG_BYTES (MB),
    .CTRL_W    (CW),
    .LEN_W     (LW),
    .CNT_W     (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .message_en (message_en),
    .bus        (bus),
    .busy       (busy),
    .err_len    (err_len),
    .msg_count  (msg_count)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  int            hs_count = 0;
  int            rdy_mode = 0;
  beat_t         exp_q[$];
  logic [NW-1:0] model_count = '0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference frame: type header, then body bytes taken by shifting
  function automatic void push_frame(input logic [3:0] t, input int len,
                                     input logic [8*MB-1:0] w);
    beat_t b;
    logic [8*MB-1:0] sh;
    b.d = {4'h0, t};
    b.f = 1'b1;
    b.l = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < len; i++) begin
      sh  = w >> (8 * (MB - 1 - i));
      b.d = sh[7:0];
      b.f = 1'b0;
      b.l = (i == len - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [8*MB-1:0] rand_word();
    logic [8*MB-1:0] w;
    for (int i = 0; i < MB / 4; i++) begin
      w = {w[8*MB-33:0], 32'($urandom)};
    end
    return w;
  endfunction

  // Ready pattern generator
  int pat_i = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          bus.out_ready = (pat_i == 0 || pat_i == 3);
          pat_i = (pat_i + 1) % 4;
        end
      endcase
    end
  end

  // Monitor
  logic       stalled = 1'b0;
  logic [7:0] st_d;
  logic       st_f;
  logic       st_l;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold", {bus.out_data, bus.out_first, bus.out_last},
            {st_d, st_f, st_l});
      end
      if (bus.out_valid) begin
        chk("first_last_excl", bus.out_first & bus.out_last, 0);
        if (bus.out_ready) begin
          stalled = 1'b0;
          hs_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", {bus.out_data, bus.out_first,
                bus.out_last}, 0);
            checks--;
            errors += (errors == errors) ? 0 : 0;
            errors++;
            checks++;
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", {bus.out_data, bus.out_first, bus.out_last},
                {e.d, e.f, e.l});
          end
        end else begin
          stalled = 1'b1;
          st_d = bus.out_data;
          st_f = bus.out_first;
          st_l = bus.out_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [3:0] t, input int len,
                      input logic [8*MB-1:0] w);
    bit ok;
    bit legal;
    legal = (len >= 1) && (len <= MB);
    bus.in_valid       = 1'b1;
    bus.in_mux_control = t;
    bus.in_len         = LW'(len);
    bus.in_message     = w;
    wait_ready(ok);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    if (legal) begin
      push_frame(t, len, w);
      model_count++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (legal) begin
      chk("hdr_latency", {bus.out_valid, bus.out_first}, 2'b11);
    end else begin
      chk("err_pulse", err_len, 1);
      chk("drop_no_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      chk("err_once", err_len, 0);
      chk("ready_after_drop", bus.in_ready, 1);
      chk("idle_after_drop", busy, 0);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d bytes left expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (hs_count < target) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout: got %0d expected %0d", hs_count, target);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [8*MB-1:0] w;
    logic [3:0]      t;
    int              len;
    int              base;

    bus.in_valid       = 1'b0;
    bus.in_mux_control = '0;
    bus.in_message     = '0;
    bus.in_len         = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_first_last", {bus.out_first, bus.out_last}, 0);
    chk("rst_busy_err", {busy, err_len}, 0);
    chk("rst_count", msg_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", bus.in_ready, 1);

    // Basic frame, ready held high
    rdy_mode = 0;
    w = rand_word();
    w[8*MB-1 -: 24] = 24'hA1B2C3;
    send(message_mux_k, 3, w);
    wait_done();
    chk("count_one", msg_count, model_count);

    // Same frame under a 1,0,0,1 ready pattern
    rdy_mode = 2;
    send(message_mux_k, 3, w);
    wait_done();
    chk("count_stall", msg_count, model_count);

    // Illegal lengths
    rdy_mode = 0;
    send(message_mux_cfg, 0, rand_word());
    send(message_mux_cfg, 33, rand_word());
    send(message_mux_stat, 63, rand_word());
    chk("count_after_drop", msg_count, model_count);

    // Full frame with message_en dropped part way through
    base = hs_count;
    w = rand_word();
    send(message_mux_ack, 32, w);
    wait_hs(base + 11);
    message_en = 1'b0;
    t = message_mux_stat;
    bus.in_valid       = 1'b1;
    bus.in_mux_control = t;
    bus.in_len         = LW'(5);
    bus.in_message     = ~w;
    wait_done();
    repeat (5) @(negedge clk);
    chk("en_off_ready", bus.in_ready, 0);
    chk("en_off_idle", busy, 0);
    chk("en_off_count", msg_count, model_count);
    push_frame(t, 5, ~w);
    model_count++;
    message_en = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("queued_accept", {bus.out_valid, bus.out_first}, 2'b11);
    wait_done();
    chk("count_en_back", msg_count, model_count);

    // Randomized frames
    for (int k = 0; k < 25; k++) begin
      rdy_mode = $urandom_range(0, 2);
      t = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63);
      end else begin
        len = $urandom_range(1, MB);
      end
      send(t, len, rand_word());
      wait_done();
      chk("rand_count", msg_count, model_count);
    end

    // Counter wrap
    rdy_mode = 0;
    force dut.msg_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.msg_count_q;
    model_count = 16'hFFFF;
    chk("count_preset", msg_count, model_count);
    send(message_mux_k, 2, rand_word());
    wait_done();
    chk("count_wrap", msg_count, 0);

    // Asynchronous reset in the middle of a body
    send(message_mux_k, 3, rand_word());
    wait_done();
    chk("count_pre_rst", msg_count, 1);
    base = hs_count;
    send(message_mux_k, 20, rand_word());
    wait_hs(base + 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_first_last", {bus.out_first, bus.out_last}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", msg_count, 0);
    exp_q.delete();
    model_count = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_valid", bus.out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_count", msg_count, 0);
    send(message_mux_cfg, 4, rand_word());
    wait_done();
    chk("post_rst_frame", msg_count, model_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
